video_timing_ctrl: RTL and testbench

- Sequences the HDMI output path: generates raster timing, drives the 3-bit { display_enable, vsync, hsync } bundle into the TMDS/serializer block, and issues pixel fetch requests one cycle ahead to the pixel source.
- Runs in the hdmi_clk (pixel clock) domain.
- Starts and stops only on frame boundaries, so the sink never sees a truncated frame.

---
 rtl/video_timing_ctrl.sv | 172 +++++++++++++++++
 tb/tb_video_timing_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_ctrl.sv
// Raster timing generator for the HDMI output path: pixel fetch requests one cycle
// ahead of the { display_enable, vsync, hsync } bundle. Req stage 1 cycle, hve 2 cycles.
// Starts and stops only on frame boundaries. Optional frame_count port: VIDEO_TIMING_CTRL_FRAME_COUNT_EN.
module video_timing_ctrl #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic        hdmi_clk,
  input  logic        reset,
  input  logic        enable,
  output logic        req_valid,
  output logic [11:0] req_x,
  output logic [11:0] req_y,
  output logic [2:0]  hve_sync,
  output logic        frame_start,
  output logic        line_start,
  output logic        busy
`ifdef VIDEO_TIMING_CTRL_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // The counters are 12 bits wide; larger rasters cannot be represented.
  generate
    if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_totals
      $fatal(1, "video_timing_ctrl: H_TOTAL/V_TOTAL must not exceed 4095");
    end
  endgenerate

  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [11:0] h;
  logic [11:0] v;
  logic        running;
  logic        h_last;
  logic        v_last;
  logic        frame_end;
  logic        in_active;
  logic        in_hsync;
  logic        in_vsync;
  logic        hs_r;
  logic        vs_r;
  logic        de_d;
  logic        hs_d;
  logic        vs_d;

  assign running   = (state != IDLE);
  assign h_last    = (h == H_LAST);
  assign v_last    = (v == V_LAST);
  assign frame_end = h_last && v_last;
  assign in_active = (h < H_ACT_END) && (v < V_ACT_END);
  assign in_hsync  = (h >= H_SYNC_BEG) && (h < H_SYNC_END);
  assign in_vsync  = (v >= V_SYNC_BEG) && (v < V_SYNC_END);
  assign busy      = running;

  // State register.
  always_ff @(posedge hdmi_clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leaving the raster is only allowed at the last pixel of a frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable)         state_nxt = RUN;
        else if (frame_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Raster counters: held at the origin while idle, free-running otherwise.
  always_ff @(posedge hdmi_clk or negedge reset) begin
    if (!reset) begin
      h <= '0;
      v <= '0;
    end else if (!running) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? 12'd0 : v + 12'd1;
    end else begin
      h <= h + 12'd1;
    end
  end

  // Request stage: registered view of the current counter position, blank when idle.
  always_ff @(posedge hdmi_clk or negedge reset) begin
    if (!reset) begin
      req_valid   <= 1'b0;
      req_x       <= '0;
      req_y       <= '0;
      hs_r        <= 1'b0;
      vs_r        <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      req_valid   <= running && in_active;
      req_x       <= (running && in_active) ? h : 12'd0;
      req_y       <= (running && in_active) ? v : 12'd0;
      hs_r        <= running && in_hsync;
      vs_r        <= running && in_vsync;
      frame_start <= running && (h == 12'd0) && (v == 12'd0);
      line_start  <= running && (h == 12'd0);
    end
  end

  // Output stage: the request stage delayed one cycle, to line up with returned pixels.
  always_ff @(posedge hdmi_clk or negedge reset) begin
    if (!reset) begin
      de_d <= 1'b0;
      hs_d <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      de_d <= req_valid;
      hs_d <= hs_r;
      vs_d <= vs_r;
    end
  end

  // Syncs are kept active-high internally; polarity is applied only at the pins.
  assign hve_sync = {de_d,
                     vs_d ? VSYNC_POL : ~VSYNC_POL,
                     hs_d ? HSYNC_POL : ~HSYNC_POL};

`ifdef VIDEO_TIMING_CTRL_FRAME_COUNT_EN
  // Frames emitted since reset; survives idle periods and wraps naturally.
  always_ff @(posedge hdmi_clk or negedge reset) begin
    if (!reset) begin
      frame_count <= '0;
    end else if (frame_start) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
module tb_video_timing_ctrl;

  localparam int   HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int   VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int   HT = HA + HF + HS + HB;   // 15
  localparam int   VT = VA + VF + VS + VB;   // 10
  localparam int   FRAME = HT * VT;          // 150
  localparam logic HPOL = 1'b0;
  localparam logic VPOL = 1'b0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        req_valid;
  logic [11:0] req_x;
  logic [11:0] req_y;
  logic [2:0]  hve_sync;
  logic        frame_start;
  logic        line_start;
  logic        busy;
`ifdef VIDEO_TIMING_CTRL_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
  ) dut (
    .hdmi_clk   (clk),
    .reset      (reset),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .hve_sync   (hve_sync),
    .frame_start(frame_start),
    .line_start (line_start),
    .busy       (busy)
`ifdef VIDEO_TIMING_CTRL_FRAME_COUNT_EN
    ,
    .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rv;
    logic [11:0] x;
    logic [11:0] y;
    logic [2:0]  hve;
    logic        fs;
    logic        ls;
    logic        busy;
  } obs_t;

  typedef struct {
    int   k;
    obs_t exp;
  } vec_t;

  typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_t;

  int      vectors = 0;
  int      miscompares = 0;
  obs_t    sb_q[$];
  mstate_t mst = M_IDLE;
  int      mpos = 0;
  int      edge_cnt = 0;
  int      m_fs_total = 0;
  logic    p_de = 1'b0, p_hs = 1'b0, p_vs = 1'b0;
  int      cyc = 0, fs_count = 0, fs_last = 0, fs_gap = 0;

  function automatic obs_t dut_obs();
    obs_t o;
    o.rv = req_valid; o.x = req_x; o.y = req_y; o.hve = hve_sync;
    o.fs = frame_start; o.ls = line_start; o.busy = busy;
    return o;
  endfunction

  function automatic obs_t mk_obs(logic rv, int x, int y, logic [2:0] hve, logic fs, logic ls, logic b);
    obs_t o;
    o.rv = rv; o.x = 12'(x); o.y = 12'(y); o.hve = hve; o.fs = fs; o.ls = ls; o.busy = b;
    return o;
  endfunction

  function automatic vec_t mk(int k, logic rv, int x, int y, logic [2:0] hve, logic fs, logic ls, logic b);
    vec_t r;
    r.k = k;
    r.exp = mk_obs(rv, x, y, hve, fs, ls, b);
    return r;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got rv=%0b x=%0d y=%0d hve=%03b fs=%0b ls=%0b busy=%0b, want rv=%0b x=%0d y=%0d hve=%03b fs=%0b ls=%0b busy=%0b",
               name, $time, got.rv, got.x, got.y, got.hve, got.fs, got.ls, got.busy,
               exp.rv, exp.x, exp.y, exp.hve, exp.fs, exp.ls, exp.busy);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // Reference model: walks a linear pixel index and predicts the outputs after each edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mst = M_IDLE; mpos = 0; edge_cnt = 0;
      p_de = 1'b0; p_hs = 1'b0; p_vs = 1'b0;
      m_fs_total = 0;
      sb_q.delete();
    end else begin
      obs_t e;
      int   h, v;
      logic run, last, s_de, s_hs, s_vs;
      edge_cnt++;
      run  = (mst != M_IDLE);
      h    = mpos % HT;
      v    = mpos / HT;
      s_de = run && (h < HA) && (v < VA);
      s_hs = run && (h >= HA + HF) && (h < HA + HF + HS);
      s_vs = run && (v >= VA + VF) && (v < VA + VF + VS);
      e.rv  = s_de;
      e.x   = s_de ? 12'(h) : 12'd0;
      e.y   = s_de ? 12'(v) : 12'd0;
      e.hve = {p_de, p_vs ? VPOL : ~VPOL, p_hs ? HPOL : ~HPOL};
      e.fs  = run && (mpos == 0);
      e.ls  = run && (h == 0);
      if (e.fs) m_fs_total++;
      p_de = s_de; p_hs = s_hs; p_vs = s_vs;
      last = (mpos == FRAME - 1);
      case (mst)
        M_IDLE:  if (enable) mst = M_RUN;
        M_RUN:   if (!enable) mst = M_DRAIN;
        M_DRAIN: begin
          if (enable)    mst = M_RUN;
          else if (last) mst = M_IDLE;
        end
        default: mst = M_IDLE;
      endcase
      if (run) mpos = last ? 0 : mpos + 1;
      e.busy = (mst != M_IDLE);
      sb_q.push_back(e);
    end
  end

  // Scoreboard checker plus frame_start period monitor.
  always @(negedge clk) begin
    cyc++;
    if (reset && sb_q.size() > 0) begin
      obs_t e;
      e = sb_q.pop_front();
      check("stream", dut_obs(), e);
    end
    if (reset && frame_start) begin
      fs_count++;
      fs_gap  = cyc - fs_last;
      fs_last = cyc;
    end
  end

  task automatic wait_pos(input int target, input string name);
    int n = 0;
    while (!(mst != M_IDLE && mpos == target) && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3 * FRAME) timeout_fail(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    obs_t rst_exp;
    int   saved, n;

    rst_exp = mk_obs(1'b0, 0, 0, {1'b0, ~VPOL, ~HPOL}, 1'b0, 1'b0, 1'b0);

    // Hand-derived first-frame checkpoints (k = edges after reset release, enable=1 from the start).
    tbl.push_back(mk(  1, 0, 0, 0, 3'b011, 0, 0, 1));
    tbl.push_back(mk(  2, 1, 0, 0, 3'b011, 1, 1, 1));
    tbl.push_back(mk(  3, 1, 1, 0, 3'b111, 0, 0, 1));
    tbl.push_back(mk(  9, 1, 7, 0, 3'b111, 0, 0, 1));
    tbl.push_back(mk( 10, 0, 0, 0, 3'b111, 0, 0, 1));
    tbl.push_back(mk( 11, 0, 0, 0, 3'b011, 0, 0, 1));
    tbl.push_back(mk( 12, 0, 0, 0, 3'b011, 0, 0, 1));
    tbl.push_back(mk( 13, 0, 0, 0, 3'b010, 0, 0, 1));
    tbl.push_back(mk( 15, 0, 0, 0, 3'b010, 0, 0, 1));
    tbl.push_back(mk( 16, 0, 0, 0, 3'b011, 0, 0, 1));
    tbl.push_back(mk( 17, 1, 0, 1, 3'b011, 0, 1, 1));
    tbl.push_back(mk( 18, 1, 1, 1, 3'b111, 0, 0, 1));
    tbl.push_back(mk( 80, 1, 3, 5, 3'b111, 0, 0, 1));
    tbl.push_back(mk( 92, 0, 0, 0, 3'b011, 0, 1, 1));
    tbl.push_back(mk(107, 0, 0, 0, 3'b011, 0, 1, 1));
    tbl.push_back(mk(108, 0, 0, 0, 3'b001, 0, 0, 1));
    tbl.push_back(mk(118, 0, 0, 0, 3'b000, 0, 0, 1));
    tbl.push_back(mk(137, 0, 0, 0, 3'b001, 0, 1, 1));
    tbl.push_back(mk(152, 1, 0, 0, 3'b011, 1, 1, 1));
    tbl.push_back(mk(153, 1, 1, 0, 3'b111, 0, 0, 1));

    // Reset state
    #1;
    check("reset_state", dut_obs(), rst_exp);
    repeat (3) @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;

    // Table-driven first frame
    for (int i = 0; i < tbl.size(); i++) begin
      n = 0;
      while (edge_cnt < tbl[i].k && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (n >= 400) timeout_fail($sformatf("tbl_k%0d", tbl[i].k));
      else          check($sformatf("tbl_k%0d", tbl[i].k), dut_obs(), tbl[i].exp);
    end

    // Drop enable mid-frame: frame must finish, then idle without new frames
    wait_pos(3 * HT, "drain_start");
    enable = 1'b0;
    n = 0;
    while (mst != M_IDLE && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3 * FRAME) timeout_fail("drain_end");
    saved = fs_count;
    repeat (20) @(negedge clk);
    check("idle_outputs", dut_obs(), rst_exp);
    check_int("idle_no_frame_start", fs_count - saved, 0);

    // Drop and re-assert within the frame: timing stays continuous
    enable = 1'b1;
    wait_pos(2 * HT, "reenable_drop");
    enable = 1'b0;
    wait_pos(5 * HT, "reenable_raise");
    enable = 1'b1;
    saved = fs_count;
    n = 0;
    while (fs_count == saved && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3 * FRAME) timeout_fail("reenable_fs");
    else                check_int("frame_period", fs_gap, FRAME);

    // Asynchronous reset mid-line, then restart at the origin
    wait_pos(2 * HT + 5, "reset_point");
    #2 reset = 1'b0;
    #1 check("async_reset", dut_obs(), rst_exp);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (edge_cnt < 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout_fail("restart_origin");
    else         check("restart_origin", dut_obs(), mk_obs(1, 0, 0, 3'b011, 1, 1, 1));

    repeat (FRAME + 5) @(negedge clk);
`ifdef VIDEO_TIMING_CTRL_FRAME_COUNT_EN
    check_int("frame_count", int'(frame_count), m_fs_total % 65536);
`endif
    enable = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    check("final_idle", dut_obs(), rst_exp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
